// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// The ALU imports the alu_control encodings from here so both ends agree.
package riscv_ctrl_pkg;

  // Controller state machine states.
  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_JAL,
    S_BEQ
  } ctrl_state_t;

  // Supported opcodes (instruction[6:0]).
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // Coarse ALU request from the state machine to the ALU decoder.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // ALU control codes understood by the ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Mux select encodings.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;
  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  // Immediate format encodings.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Moore outputs of one state, kept together so they can be registered as a unit.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_out_t;

  // Moore output table: everything not named for a state stays 0 / add.
  function automatic ctrl_out_t state_outputs(ctrl_state_t st);
    ctrl_out_t o;
    o = '0;
    o.alu_op = ALU_OP_ADD;
    case (st)
      S_FETCH: begin
        o.ir_write   = 1'b1;
        o.pc_update  = 1'b1;
        o.alu_src_a  = SRCA_PC;
        o.alu_src_b  = SRCB_FOUR;
        o.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        // Precompute the branch target as OldPC + imm.
        o.alu_src_a = SRCA_OLDPC;
        o.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        o.adr_src    = 1'b1;
        o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        o.result_src = RES_DATA;
        o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o.adr_src    = 1'b1;
        o.result_src = RES_ALUOUT;
        o.mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_RS2;
        o.alu_op    = ALU_OP_FUNCT;
      end
      S_EXECUTEI: begin
        o.alu_src_a = SRCA_RS1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        o.result_src = RES_ALUOUT;
        o.reg_write  = 1'b1;
      end
      S_JAL: begin
        // Link value OldPC + 4; the PC takes the target computed in DECODE.
        o.alu_src_a  = SRCA_OLDPC;
        o.alu_src_b  = SRCB_FOUR;
        o.result_src = RES_ALUOUT;
        o.pc_update  = 1'b1;
      end
      S_BEQ: begin
        o.alu_src_a  = SRCA_RS1;
        o.alu_src_b  = SRCB_RS2;
        o.alu_op     = ALU_OP_SUB;
        o.result_src = RES_ALUOUT;
        o.branch     = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the controller and the multicycle datapath:
// decoded instruction fields and the ALU flag in, enables and selects out.
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;

  // Controller side.
  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal_instr
  );

  // Datapath side.
  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control,
           illegal_instr
  );

endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: turns the state machine's coarse alu_op plus funct fields
// into the 3-bit ALU control code. Purely combinational.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // Select the ALU operation; unknown funct3 quietly falls back to add.
  always_comb begin
    // NOTE: default first so every path assigns alu_control and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5] = 1) can encode sub; addi ignores bit 30.
          3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: state register, next-state logic,
// registered Moore output decode, immediate-format decode and ALU decoder.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  ctrl_out_t   ctrl_q;
  ctrl_out_t   ctrl_eff;
  logic        legal_op;
  logic [2:0]  alu_control;

  // Classify the opcode as one the datapath can execute.
  always_comb begin
    legal_op = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: legal_op = 1'b1;
      default:                                          legal_op = 1'b0;
    endcase
  end

  // Next-state logic; op only matters in DECODE and MEMADR.
  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTER;
          OP_ITYPE:     state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // State register plus the Moore outputs of the state being entered, so the
  // outputs come straight from flops rather than a decode after the state flops.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so state and ctrl_q both sample pre-edge values.
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= state_outputs(S_FETCH);
    end else begin
      state  <= state_next;
      ctrl_q <= state_outputs(state_next);
    end
  end

  // While reset is held, selects look like FETCH and every enable is blocked,
  // so an abandoned instruction can never issue a partial write.
  assign ctrl_eff = rst_n ? ctrl_q : state_outputs(S_FETCH);

  assign bus.pc_write      = rst_n & (ctrl_eff.pc_update | (ctrl_eff.branch & bus.zero));
  assign bus.ir_write      = rst_n & ctrl_eff.ir_write;
  assign bus.mem_write     = rst_n & ctrl_eff.mem_write;
  assign bus.reg_write     = rst_n & ctrl_eff.reg_write;
  assign bus.adr_src       = ctrl_eff.adr_src;
  assign bus.result_src    = ctrl_eff.result_src;
  assign bus.alu_src_a     = ctrl_eff.alu_src_a;
  assign bus.alu_src_b     = ctrl_eff.alu_src_b;
  assign bus.illegal_instr = rst_n & (state == S_DECODE) & ~legal_op;

  // Immediate format depends on the opcode alone.
  always_comb begin
    bus.imm_src = IMM_I;
    case (bus.op)
      OP_LW, OP_ITYPE: bus.imm_src = IMM_I;
      OP_SW:           bus.imm_src = IMM_S;
      OP_BEQ:          bus.imm_src = IMM_B;
      OP_JAL:          bus.imm_src = IMM_J;
      default:         bus.imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl_eff.alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_control)
  );

  assign bus.alu_control = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each instruction pushes its
// expected per-cycle control vectors to a scoreboard queue, which is popped
// and compared on every falling edge.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bench-side state names used only to build expectations.
  typedef enum int {T_F, T_D, T_MA, T_MR, T_MW, T_MWR, T_ER, T_EI, T_AW, T_J, T_B, T_RST} tb_st_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;
  } obs_t;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  obs_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [1:0] model_imm(logic [6:0] o);
    if (o == SW)  return 2'b01;
    if (o == BEQ) return 2'b10;
    if (o == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] model_alu(logic [2:0] f3, logic f7, logic op5);
    case (f3)
      3'b000:  return (f7 && op5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic obs_t exp_of(tb_st_t st, logic [6:0] o, logic [2:0] f3, logic f7, logic z);
    obs_t e;
    e = '0;
    e.imm_src = model_imm(o);
    case (st)
      T_F:   begin e.pc_write = 1; e.ir_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      T_D:   begin
               e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
               e.illegal_instr = !(o == LW || o == SW || o == RT || o == IT || o == JAL || o == BEQ);
             end
      T_MA:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      T_MR:  begin e.adr_src = 1; end
      T_MW:  begin e.result_src = 2'b01; e.reg_write = 1; end
      T_MWR: begin e.adr_src = 1; e.mem_write = 1; end
      T_ER:  begin e.alu_src_a = 2'b10; e.alu_control = model_alu(f3, f7, o[5]); end
      T_EI:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = model_alu(f3, f7, o[5]); end
      T_AW:  begin e.reg_write = 1; end
      T_J:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
      T_B:   begin e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z; end
      T_RST: begin e.alu_src_b = 2'b10; e.result_src = 2'b10; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t s;
    s.pc_write      = bus.pc_write;
    s.adr_src       = bus.adr_src;
    s.mem_write     = bus.mem_write;
    s.ir_write      = bus.ir_write;
    s.reg_write     = bus.reg_write;
    s.result_src    = bus.result_src;
    s.alu_src_a     = bus.alu_src_a;
    s.alu_src_b     = bus.alu_src_b;
    s.imm_src       = bus.imm_src;
    s.alu_control   = bus.alu_control;
    s.illegal_instr = bus.illegal_instr;
    return s;
  endfunction

  task automatic check(string tag, int cyc, obs_t obs, obs_t e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, e);
    end
  endtask

  // Run one instruction from FETCH; abort_at >= 0 asserts reset in that cycle.
  task automatic run_instr(string tag, logic [6:0] o, logic [2:0] f3, logic f7, logic z, int abort_at);
    tb_st_t seq[$];
    int     n;
    obs_t   e;
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    case (o)
      LW:      seq = '{T_F, T_D, T_MA, T_MR, T_MW};
      SW:      seq = '{T_F, T_D, T_MA, T_MWR};
      RT:      seq = '{T_F, T_D, T_ER, T_AW};
      IT:      seq = '{T_F, T_D, T_EI, T_AW};
      JAL:     seq = '{T_F, T_D, T_J, T_AW};
      BEQ:     seq = '{T_F, T_D, T_B};
      default: seq = '{T_F, T_D};
    endcase
    foreach (seq[i]) q.push_back(exp_of(seq[i], o, f3, f7, z));
    n = seq.size();
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) begin
        rst_n = 1'b0;
        q.delete();
        q.push_back(exp_of(T_RST, o, f3, f7, z));
      end
      @(negedge clk);
      e = q.pop_front();
      check(tag, k, sample(), e);
      @(posedge clk);
      #1;
      if (k == abort_at) begin
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.op = BAD; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b1;

    // Reset held two cycles: enables blocked, selects as FETCH.
    @(posedge clk);
    q.push_back(exp_of(T_RST, BAD, 3'b000, 1'b0, 1'b1));
    @(negedge clk);
    check("reset_hold", 0, sample(), q.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("lw",          LW,  3'b010, 1'b0, 1'b0, -1);
    run_instr("sw",          SW,  3'b010, 1'b1, 1'b1, -1);
    run_instr("r_add",       RT,  3'b000, 1'b0, 1'b1, -1);
    run_instr("r_sub",       RT,  3'b000, 1'b1, 1'b0, -1);
    run_instr("r_slt",       RT,  3'b010, 1'b0, 1'b0, -1);
    run_instr("r_or",        RT,  3'b110, 1'b0, 1'b0, -1);
    run_instr("r_and",       RT,  3'b111, 1'b0, 1'b0, -1);
    run_instr("r_other",     RT,  3'b001, 1'b1, 1'b0, -1);
    run_instr("i_addi_b30",  IT,  3'b000, 1'b1, 1'b1, -1);
    run_instr("i_andi",      IT,  3'b111, 1'b0, 1'b0, -1);
    run_instr("jal",         JAL, 3'b000, 1'b0, 1'b0, -1);
    run_instr("beq_taken",   BEQ, 3'b000, 1'b0, 1'b1, -1);
    run_instr("beq_nottaken",BEQ, 3'b000, 1'b0, 1'b0, -1);
    run_instr("illegal",     BAD, 3'b000, 1'b1, 1'b1, -1);
    run_instr("lw_abort",    LW,  3'b010, 1'b0, 1'b0, 3);
    run_instr("after_reset", RT,  3'b000, 1'b1, 1'b0, -1);
    run_instr("illegal_end", 7'b0000000, 3'b000, 1'b0, 1'b0, -1);
    run_instr("sw_end",      SW,  3'b010, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
